// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store unit: access-size codes, LSU state encoding
// and the alignment rule used by both the bus side and the core side.
package riscv_pkg;

    localparam int DATA_W = 32;

    // Size codes follow the RISC-V load/store funct3 field.
    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
        case (size)
            LDST_H, LDST_HU: return off[0];
            LDST_W:          return off != 2'b00;
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/halfword out of a bus read word and extends it to 32 bits.
// Purely combinational; unknown size codes pass the whole word through.
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  logic [1:0]        off_i,
    input  logic [2:0]        size_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lanes[gi] = word_i[8*gi +: 8];
    end

    assign byte_sel = lanes[off_i];
    assign half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        data_o = word_i;
        case (size_i)
            LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: data_o = {24'h0, byte_sel};
            LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
            LDST_HU: data_o = {16'h0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: issues one single-port bus access per core request, stalls the core
// until acknowledge or timeout, and returns aligned, extended load data.
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [31:0]       core_addr_i,
    input  logic [31:0]       core_wd_i,
    output logic [31:0]       core_rd_o,
    output logic              core_stall_o,
    output logic              core_misalign_o,
    output logic              core_fault_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_addr_o,
    output logic [31:0]       mem_wd_o,
    input  logic              mem_ready_i,
    input  logic [31:0]       mem_rd_i
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    lsu_state_t         state_q, state_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [DATA_W-1:0]  rd_q, rd_d;
    logic [1:0]         off_q, off_d;
    logic [2:0]         size_q, size_d;
    logic               fault_q, fault_d;

    logic               misalign;
    logic               req_ok;
    logic               active;
    logic               tmo_hit;
    logic [3:0]         be_st;
    logic [3:0]         be;
    logic [31:0]        wd_rep;
    logic [31:0]        rd_ext;

    assign misalign = is_misaligned(core_size_i, core_addr_i[1:0]);
    assign req_ok   = core_req_i & ~misalign;
    assign active   = req_ok & (state_q != DONE);
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            rd_q    <= '0;
            off_q   <= 2'b00;
            size_q  <= LDST_W;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            rd_q    <= rd_d;
            off_q   <= off_d;
            size_q  <= size_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        rd_d    = rd_q;
        off_d   = off_q;
        size_d  = size_q;
        fault_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!req_ok) begin
                    // Core flushed the access (trap/redirect): abandon quietly.
                    state_d = IDLE;
                end else if (mem_ready_i) begin
                    state_d = DONE;
                    if (!core_we_i) begin
                        rd_d   = mem_rd_i;
                        off_d  = core_addr_i[1:0];
                        size_d = core_size_i;
                    end
                end else if (tmo_hit) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                    rd_d    = '0;
                    off_d   = core_addr_i[1:0];
                    size_d  = core_size_i;
                end else if (TIMEOUT_CYCLES != 0) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        be_st = 4'b0000;
        case (core_size_i)
            LDST_B:  be_st = 4'b0001 << core_addr_i[1:0];
            LDST_H:  be_st = 4'b0011 << {core_addr_i[1], 1'b0};
            LDST_W:  be_st = 4'b1111;
            default: be_st = 4'b0000;
        endcase
    end

    assign be = core_we_i ? be_st : 4'b1111;

    // Each byte lane carries the lane-matching slice, so the memory only needs the enables.
    for (genvar gi = 0; gi < 4; gi++) begin : g_wd_lane
        assign wd_rep[8*gi +: 8] = (core_size_i == LDST_B) ? core_wd_i[7:0] :
                                   (core_size_i == LDST_H) ? core_wd_i[8*(gi%2) +: 8] :
                                                             core_wd_i[8*gi +: 8];
    end

    lsu_load_align u_load_align (
        .word_i (rd_q),
        .off_i  (off_q),
        .size_i (size_q),
        .data_o (rd_ext)
    );

    // Outputs are gated by reset so the bus is released the instant rst_ni falls.
    assign mem_req_o       = rst_ni & active;
    assign mem_we_o        = rst_ni & active & core_we_i;
    assign core_stall_o    = rst_ni & active;
    assign core_misalign_o = rst_ni & core_req_i & misalign;
    assign core_fault_o    = fault_q;
    assign mem_be_o        = {4{rst_ni}} & be;
    assign mem_addr_o      = {32{rst_ni}} & {core_addr_i[31:2], 2'b00};
    assign mem_wd_o        = {32{rst_ni}} & wd_rep;
    assign core_rd_o       = {32{rst_ni}} & rd_ext;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: expected bus fields and load results are queued when
// each access is driven and popped when the unit presents them.
module tb_riscv_lsu;
    import riscv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_misalign_o;
    logic        core_fault_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic        mem_ready_i;
    logic [31:0] mem_rd_i;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    riscv_lsu #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .core_req_i      (core_req_i),
        .core_we_i       (core_we_i),
        .core_size_i     (core_size_i),
        .core_addr_i     (core_addr_i),
        .core_wd_i       (core_wd_i),
        .core_rd_o       (core_rd_o),
        .core_stall_o    (core_stall_o),
        .core_misalign_o (core_misalign_o),
        .core_fault_o    (core_fault_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_be_o        (mem_be_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wd_o        (mem_wd_o),
        .mem_ready_i     (mem_ready_i),
        .mem_rd_i        (mem_rd_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_ext(input logic [31:0] w, input logic [1:0] off,
                                              input logic [2:0] sz);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * off));
        h = 16'(w >> (16 * off[1]));
        case (sz)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // One complete access: request cycle, delay+1 busy cycles with ready on the last, done cycle.
    task automatic xact(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] data, input int delay,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd);
        exp_t e;
        int   stalls;
        e.tag = {tag, "/be"};
        e.val = {28'h0, exp_be};
        sb_q.push_back(e);
        e.tag = we ? {tag, "/wd"} : {tag, "/rd"};
        e.val = we ? exp_wd : model_ext(data, addr[1:0], size);
        sb_q.push_back(e);

        @(negedge clk_i);
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = we ? data : 32'h0;
        mem_ready_i = 1'b0;
        mem_rd_i    = 32'h5A5A5A5A;
        #1;
        check({tag, "/addr"}, mem_addr_o, {addr[31:2], 2'b00});
        check_bit({tag, "/req"}, mem_req_o, 1'b1);
        check_bit({tag, "/we"}, mem_we_o, we);
        e = sb_q.pop_front();
        check(e.tag, {28'h0, mem_be_o}, e.val);
        if (we) begin
            e = sb_q.pop_front();
            check(e.tag, mem_wd_o, e.val);
        end
        stalls = core_stall_o ? 1 : 0;

        for (int d = 0; d <= delay; d++) begin
            @(negedge clk_i);
            mem_ready_i = (d == delay);
            mem_rd_i    = (d == delay && !we) ? data : 32'h5A5A5A5A;
            #1;
            if (core_stall_o) stalls++;
        end

        @(negedge clk_i);
        mem_ready_i = 1'b0;
        mem_rd_i    = 32'h0;
        #1;
        check({tag, "/stall_cycles"}, 32'(stalls), 32'(delay + 2));
        check_bit({tag, "/stall_done"}, core_stall_o, 1'b0);
        check_bit({tag, "/req_done"}, mem_req_o, 1'b0);
        check_bit({tag, "/fault"}, core_fault_o, 1'b0);
        if (!we) begin
            e = sb_q.pop_front();
            check(e.tag, core_rd_o, e.val);
        end
        @(negedge clk_i);
        core_req_i = 1'b0;
    endtask

    // Access that is never acknowledged: expect 1 request + 16 busy stall cycles, then a fault.
    task automatic tmo(input string tag, input logic we, input logic [31:0] addr);
        int   stalls;
        logic seen;
        @(negedge clk_i);
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = LDST_W;
        core_addr_i = addr;
        core_wd_i   = 32'h600DF00D;
        mem_ready_i = 1'b0;
        #1;
        stalls = core_stall_o ? 1 : 0;
        seen   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            #1;
            if (core_stall_o) begin
                stalls++;
            end else begin
                seen = 1'b1;
                break;
            end
        end
        check_bit({tag, "/released"}, seen, 1'b1);
        check_bit({tag, "/fault"}, core_fault_o, 1'b1);
        check({tag, "/stall_cycles"}, 32'(stalls), 32'd17);
        if (!we) check({tag, "/rd_zero"}, core_rd_o, 32'h0);
        @(negedge clk_i);
        core_req_i = 1'b0;
        #1;
        check_bit({tag, "/fault_pulse"}, core_fault_o, 1'b0);
    endtask

    initial begin
        rst_ni      = 1'b0;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = LDST_W;
        core_addr_i = 32'h1000;
        core_wd_i   = 32'h0;
        mem_ready_i = 1'b0;
        mem_rd_i    = 32'h0;
        #12;
        check_bit("reset/mem_req", mem_req_o, 1'b0);
        check_bit("reset/stall", core_stall_o, 1'b0);
        check_bit("reset/fault", core_fault_o, 1'b0);
        check("reset/rd", core_rd_o, 32'h0);
        check("reset/be", {28'h0, mem_be_o}, 32'h0);
        @(negedge clk_i);
        core_req_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Loads with extension
        xact("LB",    1'b0, LDST_B,  32'h1003, 32'h80123456, 0, 4'hF, 32'h0);
        xact("LHU",   1'b0, LDST_HU, 32'h1002, 32'hBEEF1234, 0, 4'hF, 32'h0);
        xact("LH",    1'b0, LDST_H,  32'h1000, 32'h12348001, 1, 4'hF, 32'h0);
        xact("LBU",   1'b0, LDST_BU, 32'h1001, 32'h00009A00, 0, 4'hF, 32'h0);
        xact("LW",    1'b0, LDST_W,  32'h1004, 32'hA5C3E1F0, 3, 4'hF, 32'h0);
        xact("LINV",  1'b0, 3'b011,  32'h1008, 32'h87654321, 0, 4'hF, 32'h0);

        // Stores with byte enables and lane replication
        xact("SB",    1'b1, LDST_B,  32'h2001, 32'h000000AB, 0, 4'b0010, 32'hABABABAB);
        xact("SH",    1'b1, LDST_H,  32'h2002, 32'h1234CDEF, 0, 4'b1100, 32'hCDEFCDEF);
        xact("SW",    1'b1, LDST_W,  32'h2000, 32'hCAFEF00D, 2, 4'b1111, 32'hCAFEF00D);

        // Invalid store size: no byte enabled; flush it from the core side
        @(negedge clk_i);
        core_req_i = 1'b1; core_we_i = 1'b1; core_size_i = 3'b111; core_addr_i = 32'h2004;
        #1;
        check("SINV/be", {28'h0, mem_be_o}, 32'h0);
        @(negedge clk_i);
        core_req_i = 1'b0;

        // Misaligned accesses never reach the bus and never stall
        @(negedge clk_i);
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = LDST_W; core_addr_i = 32'h3002;
        #1;
        check_bit("MIS_LW/misalign", core_misalign_o, 1'b1);
        check_bit("MIS_LW/mem_req", mem_req_o, 1'b0);
        check_bit("MIS_LW/stall", core_stall_o, 1'b0);
        @(negedge clk_i);
        core_size_i = LDST_H; core_addr_i = 32'h3001;
        #1;
        check_bit("MIS_LH/misalign", core_misalign_o, 1'b1);
        check_bit("MIS_LH/stall", core_stall_o, 1'b0);
        @(negedge clk_i);
        core_req_i = 1'b0;
        #1;
        check_bit("MIS_idle/misalign", core_misalign_o, 1'b0);
        xact("LHU_AL", 1'b0, LDST_HU, 32'h3002, 32'h7FFF0001, 0, 4'hF, 32'h0);

        // Ready arriving in the same cycle as the timeout wins
        xact("LW_EDGE", 1'b0, LDST_W, 32'h7000, 32'h11223344, 15, 4'hF, 32'h0);
        tmo("TMO_SW", 1'b1, 32'h4000);
        tmo("TMO_LW", 1'b0, 32'h7004);

        // Request withdrawn mid-access
        @(negedge clk_i);
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = LDST_W; core_addr_i = 32'h5000;
        mem_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        core_req_i = 1'b0;
        #1;
        check_bit("FLUSH/mem_req", mem_req_o, 1'b0);
        check_bit("FLUSH/stall", core_stall_o, 1'b0);
        @(negedge clk_i);
        #1;
        check_bit("FLUSH/fault", core_fault_o, 1'b0);
        xact("LW_POSTFLUSH", 1'b0, LDST_W, 32'h5004, 32'h13579BDF, 0, 4'hF, 32'h0);

        // Reset during a pending access releases the bus at once
        @(negedge clk_i);
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = LDST_W; core_addr_i = 32'h6000;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_bit("RST_MID/mem_req", mem_req_o, 1'b0);
        check_bit("RST_MID/stall", core_stall_o, 1'b0);
        @(negedge clk_i);
        core_req_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        xact("LW_POSTRST", 1'b0, LDST_W, 32'h6004, 32'h0F1E2D3C, 1, 4'hF, 32'h0);

        check("scoreboard/empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
